pht_update_scheduler: RTL
=========================

Name: pht_update_scheduler

Overview:
- Owns the single memory port of the global-predictor pattern history table (PHT): 2-bit saturating counters indexed by global history.
- Arbitrates fetch-stage prediction lookups (highest priority) against queued branch-resolution updates, which it applies as read-capture-write sequences.
- Also holds the global history register (GHR) and performs the post-reset PHT initialisation sweep.
- Sits between fetch/branch-resolve logic and a synchronous single-port PHT RAM with 1-cycle read latency.

Parameters:
- IDX_W, 12, PHT index / GHR width; the PHT has 2^IDX_W entries.
- DEPTH, 4, update FIFO depth; power of two, minimum 2.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- lookup_valid  in  1  prediction request this cycle
- lookup_index  in  IDX_W  PHT index for the request
- resp_valid  out  1  lookup response valid (one cycle after lookup_valid)
- resp_counter  out  2  counter value returned
- resp_taken  out  1  resp_counter[1]
- upd_valid  in  1  resolved-branch update offered
- upd_index  in  IDX_W  index used when that branch was predicted
- upd_taken  in  1  resolved outcome
- upd_ready  out  1  FIFO not full
- ghr  out  IDX_W  global history register
- init_done  out  1  initialisation sweep complete
- pht_en  out  1  RAM access enable
- pht_we  out  1  RAM write enable
- pht_addr  out  IDX_W  RAM address
- pht_wdata  out  2  RAM write data
- pht_rdata  in  2  RAM read data, valid the cycle after a read

Behaviour:
- Reset (async, RESET=1): state INIT, sweep address 0, FIFO empty, ghr=0. All outputs 0, except upd_ready=1.
- INIT state:
  - Each cycle writes 2'b01 to pht_addr=sweep address, then increments the address.
  - After entry 2^IDX_W-1: init_done=1, go to IDLE. The sweep takes exactly 2^IDX_W cycles.
  - A lookup during INIT gets resp_valid=1, resp_counter=2'b01 the next cycle, with no RAM access.
  - Enqueue is allowed during INIT; entries are drained after INIT.
- Lookup (after INIT): lookup_valid at cycle t drives pht_en=1, pht_we=0, pht_addr=lookup_index at t. At t+1, resp_valid=1 and resp_counter=pht_rdata. Lookup always wins the port.
- Enqueue:
  - Accepted when upd_valid && upd_ready. Pushes {upd_index, upd_taken}.
  - On accept, ghr <= {ghr[IDX_W-2:0], upd_taken}.
  - upd_ready = !full, computed from registered count only; a pop in the same cycle does not raise it.
  - Push and pop in the same cycle when not full: count unchanged.
- FSM (post-INIT):
  - IDLE -> RD when the FIFO is non-empty.
  - RD: if lookup_valid, stay. Else issue a read of the head index and go to CAP.
  - CAP: no port use. Capture pht_rdata and compute next = taken ? sat_inc : sat_dec. 11 stays 11 on taken; 00 stays 00 on not-taken. Go to WR.
  - WR: if lookup_valid, stay and hold the computed value. Else write next to the head index, pop, and go to RD if further entries remain, else IDLE.
- Throughput: 3 cycles per update with no lookup contention.
- Ordering: updates apply in FIFO order, one at a time, so same-index back-to-back updates are never lost.
- Lookup in the same cycle as a RD/WR attempt: lookup served, RMW slips one cycle. The response reflects RAM contents (stale if a write is pending; see optional feature).
- Reset mid-operation: the in-flight RMW and the FIFO are discarded; INIT restarts.

Optional Feature:
- Macro: PHT_BYPASS_EN.
- Defined: if a lookup's index equals the head index while the FSM is in WR (value computed, write not yet done), resp_counter at t+1 returns the computed next value instead of pht_rdata.
- Undefined: no forwarding; the lookup returns RAM contents.
- Latency and handshakes are identical in both builds.

Decomposition:
- Shared package pht_pkg:
  - counter constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - INIT_VALUE=WNT
  - FSM state enum {INIT, IDLE, RD, CAP, WR}
  - saturating increment/decrement functions
- One natural sub-module: pht_update_fifo (parameterised DEPTH-entry sync FIFO with push/pop/full/empty/count).

Test Plan (bench uses IDX_W=4, DEPTH=4):
- Release reset, idle -> 16 writes of 01 to addrs 0..15 on consecutive cycles; init_done rises at cycle 16; a lookup during INIT returns 01.
- Post-init, enqueue idx 3 taken x3 -> RAM[3] sequence 10, 11, 11 (saturates); ghr=4'b0111.
- Enqueue idx 5 not-taken x2 from initial 01 -> RAM[5]=00 and stays 00; ghr shifts in 0s.
- Enqueue 5 updates back-to-back with no pops -> upd_ready=0 after the 4th accept; the 5th is accepted only the cycle after the first pop.
- Hold lookup_valid continuously with one queued update -> FSM stays in RD, no RAM write; release -> write completes 3 cycles later.
- Lookup idx 7 while an update to idx 7 is in WR -> with PHT_BYPASS_EN, returns the new value; without it, returns the old value.
- Assert RESET during CAP -> FIFO empty, ghr=0, INIT restarts at addr 0.

Source files
------------

// File: rtl/pht_pkg.sv
// Shared constants, FSM states and saturating-counter helpers for the PHT update scheduler.
package pht_pkg;

  localparam logic [1:0] SNT        = 2'b00;
  localparam logic [1:0] WNT        = 2'b01;
  localparam logic [1:0] WT         = 2'b10;
  localparam logic [1:0] ST         = 2'b11;
  localparam logic [1:0] INIT_VALUE = WNT;

  typedef enum logic [2:0] {INIT, IDLE, RD, CAP, WR} state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == ST) ? ST : v + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == SNT) ? SNT : v - 2'b01;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// DEPTH-entry synchronous FIFO holding pending {index, taken} PHT updates.
// Push while full and pop while empty are ignored.
module pht_update_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pht_update_scheduler.sv
// Owns the PHT RAM port: init sweep, lookups (top priority) and queued read-modify-write updates.
// Define PHT_BYPASS_EN to forward a pending WR value to a same-index lookup.
module pht_update_scheduler
  import pht_pkg::*;
#(
  parameter int IDX_W = 12,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_index,
  output logic             resp_valid,
  output logic [1:0]       resp_counter,
  output logic             resp_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic [IDX_W-1:0] ghr,
  output logic             init_done,
  output logic             pht_en,
  output logic             pht_we,
  output logic [IDX_W-1:0] pht_addr,
  output logic [1:0]       pht_wdata,
  input  logic [1:0]       pht_rdata
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e           r_state;
  logic [IDX_W-1:0] r_sweep;
  logic [IDX_W-1:0] r_ghr;
  logic             r_init_done;
  logic             r_resp_valid;
  logic             r_resp_ram;
  logic [1:0]       r_resp_val;
  logic [1:0]       r_next;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_wr_go;
  logic             w_fwd;
  logic [IDX_W:0]   w_head;
  logic [CNT_W-1:0] w_count;

  assign upd_ready    = !w_full;
  assign w_accept     = upd_valid && !w_full;
  assign w_wr_go      = (r_state == WR) && !lookup_valid;
  assign ghr          = r_ghr;
  assign init_done    = r_init_done;
  assign resp_valid   = r_resp_valid;
  assign resp_counter = !r_resp_valid ? SNT : (r_resp_ram ? pht_rdata : r_resp_val);
  assign resp_taken   = resp_counter[1];

`ifdef PHT_BYPASS_EN
  assign w_fwd = (r_state == WR) && (lookup_index == w_head[IDX_W:1]);
`else
  assign w_fwd = 1'b0;
`endif

  pht_update_fifo #(.DEPTH(DEPTH), .W(IDX_W + 1)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_accept),
    .i_data  ({upd_index, upd_taken}),
    .i_pop   (w_wr_go),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Port owner: sweep during INIT, otherwise lookup first, then the RMW read/write.
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = SNT;
    if (!RESET) begin
      if (r_state == INIT) begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = r_sweep;
        pht_wdata = INIT_VALUE;
      end else if (lookup_valid) begin
        pht_en   = 1'b1;
        pht_addr = lookup_index;
      end else if (r_state == RD) begin
        pht_en   = 1'b1;
        pht_addr = w_head[IDX_W:1];
      end else if (r_state == WR) begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = w_head[IDX_W:1];
        pht_wdata = r_next;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= INIT;
      r_sweep      <= '0;
      r_ghr        <= '0;
      r_init_done  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_ram   <= 1'b0;
      r_resp_val   <= SNT;
      r_next       <= SNT;
    end else begin
      r_resp_valid <= lookup_valid;
      r_resp_ram   <= 1'b0;
      r_resp_val   <= SNT;
      if (lookup_valid) begin
        if (r_state == INIT) begin
          r_resp_val <= INIT_VALUE;
        end else if (w_fwd) begin
          r_resp_val <= r_next;
        end else begin
          r_resp_ram <= 1'b1;
        end
      end

      if (w_accept) r_ghr <= {r_ghr[IDX_W-2:0], upd_taken};

      case (r_state)
        INIT: begin
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == '1) begin
            r_init_done <= 1'b1;
            r_state     <= IDLE;
          end
        end
        IDLE: if (!w_empty) r_state <= RD;
        RD:   if (!lookup_valid) r_state <= CAP;
        CAP: begin
          r_next  <= w_head[0] ? sat_inc(pht_rdata) : sat_dec(pht_rdata);
          r_state <= WR;
        end
        WR:   if (!lookup_valid) r_state <= (w_count > CNT_W'(1)) ? RD : IDLE;
        default: r_state <= INIT;
      endcase
    end
  end

endmodule
